// File: rtl/cache_arbiter_if.sv
// Cache/memory handshake bundle between the two caches, the arbiter and physical memory.
// The arbiter sits on the slave modport; the caches and memory model sit on the master modport.
interface cache_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client line arbiter: I-cache and D-cache share one physical-memory port, one
// transaction at a time, alternating under contention, with a saturating contention counter.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [2:0] {StIdle, StServeI, StServeD, StRespI, StRespD} state_e;

  state_e            state_q;
  logic              last_d_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [LINE_W-1:0] req_wdata_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  conflict_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic              icache_resp_q;
  logic              dcache_resp_q;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req   = bus.icache_read;
  assign d_req   = bus.dcache_read | bus.dcache_write;
  // On a tie, I wins unless I was the last one granted.
  assign grant_i = i_req & (~d_req | last_d_q);
  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      last_d_q      <= 1'b1;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      line_q        <= '0;
      conflict_q    <= '0;
      pmem_read_q   <= 1'b0;
      pmem_write_q  <= 1'b0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req && d_req && (conflict_q != '1)) begin
            conflict_q <= conflict_q + CNT_W'(1);
          end
          if (grant_i) begin
            state_q      <= StServeI;
            last_d_q     <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= bus.icache_address;
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
          end else if (grant_d) begin
            // Read and write asserted together is a writeback.
            state_q      <= StServeD;
            last_d_q     <= 1'b1;
            req_write_q  <= bus.dcache_write;
            req_addr_q   <= bus.dcache_address;
            req_wdata_q  <= bus.dcache_wdata;
            pmem_read_q  <= ~bus.dcache_write;
            pmem_write_q <= bus.dcache_write;
          end
        end
        StServeI, StServeD: begin
          if (bus.pmem_resp) begin
            if (!req_write_q) begin
              line_q <= bus.pmem_rdata;
            end
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            if (state_q == StServeI) begin
              state_q       <= StRespI;
              icache_resp_q <= 1'b1;
            end else begin
              state_q       <= StRespD;
              dcache_resp_q <= 1'b1;
            end
          end
        end
        StRespI, StRespD: begin
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = req_addr_q;
  assign bus.pmem_wdata   = req_wdata_q;
  assign bus.icache_resp  = icache_resp_q;
  assign bus.dcache_resp  = dcache_resp_q;
  assign bus.icache_rdata = line_q;
  assign bus.dcache_rdata = line_q;
  assign conflict_count   = conflict_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed cycle table, saturation run, random run,
// all cross-checked every cycle against a transaction-level reference model.
module tb_cache_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  logic clk;
  logic rst;
  logic [31:0] conflict_count;
  logic [3:0]  sat_count;

  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) sat_bus ();

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(32)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .conflict_count (conflict_count)
  );

  // Narrow-counter copy sees the same stimulus; only its counter is checked.
  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_sat (
    .clk            (clk),
    .rst            (rst),
    .bus            (sat_bus.slave),
    .conflict_count (sat_count)
  );

  assign sat_bus.icache_read    = bus.icache_read;
  assign sat_bus.icache_address = bus.icache_address;
  assign sat_bus.dcache_read    = bus.dcache_read;
  assign sat_bus.dcache_write   = bus.dcache_write;
  assign sat_bus.dcache_address = bus.dcache_address;
  assign sat_bus.dcache_wdata   = bus.dcache_wdata;
  assign sat_bus.pmem_rdata     = bus.pmem_rdata;
  assign sat_bus.pmem_resp      = bus.pmem_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = free, 1 = memory access outstanding, 2 = completion cycle.
  int                phase;
  bit                owner_d;
  bit                m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_line;
  bit                m_last_d;
  longint            m_conflicts;

  function automatic void model_reset();
    phase = 0; owner_d = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    m_line = '0; m_last_d = 1'b1; m_conflicts = 0;
  endfunction

  task automatic model_check();
    check("pmem_read", bus.pmem_read, (phase == 1) && !m_write);
    check("pmem_write", bus.pmem_write, (phase == 1) && m_write);
    if (phase == 1) check("pmem_address", bus.pmem_address, m_addr);
    if (phase == 1 && m_write) check("pmem_wdata", bus.pmem_wdata, m_wdata);
    check("icache_resp", bus.icache_resp, (phase == 2) && !owner_d);
    check("dcache_resp", bus.dcache_resp, (phase == 2) && owner_d);
    check("icache_rdata", bus.icache_rdata, m_line);
    check("dcache_rdata", bus.dcache_rdata, m_line);
    check("conflict_count", conflict_count, 32'(m_conflicts));
    check("conflict_sat", sat_count, (m_conflicts > 15) ? 4'd15 : 4'(m_conflicts));
  endtask

  function automatic void model_next();
    bit ir, dr, pick_d;
    if (!rst) begin
      model_reset();
      return;
    end
    ir = bus.icache_read;
    dr = bus.dcache_read | bus.dcache_write;
    case (phase)
      0: if (ir || dr) begin
        if (ir && dr) begin
          m_conflicts++;
          pick_d = !m_last_d;
        end else begin
          pick_d = dr;
        end
        owner_d  = pick_d;
        m_last_d = pick_d;
        m_write  = pick_d && bus.dcache_write;
        m_addr   = pick_d ? bus.dcache_address : bus.icache_address;
        if (pick_d) m_wdata = bus.dcache_wdata;
        phase = 1;
      end
      1: if (bus.pmem_resp) begin
        if (!m_write) m_line = bus.pmem_rdata;
        phase = 2;
      end
      default: phase = 0;
    endcase
  endfunction

  // Call with this cycle's inputs already applied.
  task automatic step();
    model_check();
    model_next();
    @(negedge clk);
  endtask

  typedef struct {
    bit rst, ir, dr, dw, pr;
    bit e_pr, e_pw, e_ir, e_dr;
    int e_cnt;
  } vec_t;

  function automatic vec_t v(bit r, bit ir, bit dr, bit dw, bit pr,
                             bit epr, bit epw, bit eir, bit edr, int ecnt);
    vec_t x;
    x.rst = r; x.ir = ir; x.dr = dr; x.dw = dw; x.pr = pr;
    x.e_pr = epr; x.e_pw = epw; x.e_ir = eir; x.e_dr = edr; x.e_cnt = ecnt;
    return x;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  vec_t tbl[$];
  logic [LINE_W-1:0] line_a5;

  initial begin
    line_a5 = {32{8'hA5}};
    //                rst ir dr dw pr  epr epw eir edr cnt
    // single I read, pmem_resp at cycle 4
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // D writeback
    tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 1,  0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // contention from reset, both held: I, D, I, D
    tbl.push_back(v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 0, 2));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 1, 2));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 0, 2));
    tbl.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 0, 3));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 1, 0, 3));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 0, 3));
    tbl.push_back(v(1, 1, 1, 0, 1,  1, 0, 0, 0, 4));
    tbl.push_back(v(1, 1, 1, 0, 0,  0, 0, 0, 1, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 4));
    // I read abandoned by the cache mid-flight still completes
    tbl.push_back(v(1, 1, 0, 0, 0,  0, 0, 0, 0, 4));
    tbl.push_back(v(1, 1, 0, 0, 0,  1, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  1, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 1,  1, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 1, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 4));
    // reset during SERVE_D: no completion, counter cleared
    tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 1, 0,  0, 1, 0, 0, 4));
    tbl.push_back(v(0, 0, 0, 1, 0,  0, 1, 0, 0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // read+write together is a write
    tbl.push_back(v(1, 0, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 1,  0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // pmem_resp held high: ignored in IDLE, completes exactly one transaction
    tbl.push_back(v(1, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1,  0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    rst = 1'b0;
    bus.icache_read    = 1'b0;
    bus.icache_address = 32'h0000_0040;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = 32'h8000_0100;
    bus.dcache_wdata   = {8{32'h1234_5678}};
    bus.pmem_rdata     = line_a5;
    bus.pmem_resp      = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();

    foreach (tbl[i]) begin
      rst              = tbl[i].rst;
      bus.icache_read  = tbl[i].ir;
      bus.dcache_read  = tbl[i].dr;
      bus.dcache_write = tbl[i].dw;
      bus.pmem_resp    = tbl[i].pr;
      check($sformatf("tbl[%0d] pmem_read", i), bus.pmem_read, tbl[i].e_pr);
      check($sformatf("tbl[%0d] pmem_write", i), bus.pmem_write, tbl[i].e_pw);
      check($sformatf("tbl[%0d] icache_resp", i), bus.icache_resp, tbl[i].e_ir);
      check($sformatf("tbl[%0d] dcache_resp", i), bus.dcache_resp, tbl[i].e_dr);
      check($sformatf("tbl[%0d] conflict_count", i), conflict_count, tbl[i].e_cnt);
      if (tbl[i].e_ir) check($sformatf("tbl[%0d] icache_rdata", i), bus.icache_rdata, line_a5);
      if (tbl[i].e_pw) begin
        check($sformatf("tbl[%0d] pmem_address", i), bus.pmem_address, 32'h8000_0100);
        check($sformatf("tbl[%0d] pmem_wdata", i), bus.pmem_wdata, {8{32'h1234_5678}});
      end
      step();
    end

    // Saturation: 20 contended grants, each idle/serve/resp with immediate pmem_resp.
    rst = 1'b0;
    bus.icache_read = 1'b0; bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
    bus.pmem_resp = 1'b0;
    step();
    rst = 1'b1;
    bus.icache_read = 1'b1; bus.dcache_read = 1'b1; bus.pmem_resp = 1'b1;
    repeat (60) step();
    check("sat wide count after 20 grants", conflict_count, 32'd20);
    check("sat narrow count after 20 grants", sat_count, 4'd15);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst                = ($urandom_range(0, 63) != 0);
      bus.icache_read    = ($urandom_range(0, 2) != 0);
      bus.dcache_read    = $urandom_range(0, 1) == 1;
      bus.dcache_write   = ($urandom_range(0, 2) == 0);
      bus.icache_address = $urandom;
      bus.dcache_address = $urandom;
      bus.dcache_wdata   = rand_line();
      bus.pmem_rdata     = rand_line();
      bus.pmem_resp      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
